pipe_mux_tree: RTL and testbench
================================

PIPE_MUX_TREE -- requirements
Module: pipe_mux_tree

Interface
REQ-001 The block SHALL have parameter NUM_SEL, default 4, giving the select width and the tree depth in levels; legal range 1..8.
REQ-002 The block SHALL have parameter DATA_W, default 1, giving the width of each input channel; legal range 1..64.
REQ-003 The block SHALL have derived parameter NUM_IN = 2**NUM_SEL, giving the input channel count; it is not overridable.
REQ-004 The block SHALL have clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have in_data, input, NUM_IN*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 The block SHALL have in_sel, input, NUM_SEL bits: the channel index to forward.
REQ-008 The block SHALL have in_valid, input, 1 bit: in_data and in_sel are valid this cycle.
REQ-009 The block SHALL have in_ready, output, 1 bit: the block accepts a transfer this cycle.
REQ-010 The block SHALL have out_data, output, DATA_W bits: the selected channel value.
REQ-011 The block SHALL have out_valid, output, 1 bit: out_data is valid this cycle.
REQ-012 The block SHALL have out_ready, input, 1 bit: the downstream consumer accepts out_data this cycle.

Function
REQ-013 A transfer SHALL occur on each edge where valid && ready; in_data and in_sel SHALL be sampled only on accepted input transfers.
REQ-014 The tree SHALL have NUM_SEL registered stages; stage i SHALL hold 2**(NUM_SEL-1-i) words of DATA_W, a valid bit, and the unused select bits sel[NUM_SEL-1:i+1].
REQ-015 Stage 0 SHALL register the pairwise selection of in_data using in_sel[0]: word j = in_sel[0] ? channel 2j+1 : channel 2j.
REQ-016 Stage i>0 SHALL register the pairwise selection of the stage i-1 words using the carried sel[i].
REQ-017 out_data and out_valid SHALL be driven directly from the last stage's registers; there SHALL be no combinational path from in_data to out_data.
REQ-018 Each stage SHALL be ready when its valid bit is 0 or the next stage is ready; the ready of the last stage SHALL be out_ready; in_ready SHALL equal stage 0's ready.
REQ-019 A stage that is ready SHALL load the upstream word and valid bit, and a stage that is not ready SHALL hold all its contents.
REQ-020 Latency SHALL be exactly NUM_SEL cycles from an accepted input to out_valid when there is no backpressure.
REQ-021 Sustained throughput SHALL be one transfer per cycle while out_ready=1.
REQ-022 Bubbles SHALL collapse: an invalid stage SHALL accept new data even while downstream is stalled.
REQ-023 When every stage is valid and out_ready=0, the pipe SHALL be full and in_ready SHALL be 0; no data SHALL be lost or duplicated.
REQ-024 A simultaneous accept at the input and output while the pipe is full SHALL advance every stage by one.
REQ-025 When NUM_SEL=1, the tree SHALL be a single registered 2:1 stage with latency 1.
REQ-026 out_data SHALL hold its last value while out_valid=0; the bench SHALL NOT check out_data while out_valid=0.

Reset
REQ-027 While rst_n=0 at an edge, all stage valid bits SHALL clear to 0, and all data and carried-select registers SHALL clear to 0.
REQ-028 Reset SHALL take effect even mid-transfer; in-flight data SHALL be discarded.
REQ-029 After reset, out_valid SHALL be 0, out_data SHALL be 0, and in_ready SHALL be 1.

Structure
REQ-030 Package pipe_mux_pkg SHALL hold the default NUM_SEL/DATA_W constants and a function returning the stage word count for level i.
REQ-031 One sub-module, mux_tree_stage, SHALL implement one registered halving level, parameterised by word count, DATA_W and carried select width; the top SHALL instantiate NUM_SEL of them in a generate loop.

Verification
REQ-032 With NUM_SEL=3, DATA_W=8, channels k=0x10+k, in_sel=5, single transfer, out_ready=1 -> out_valid rises exactly 3 cycles later with out_data=0x15.
REQ-033 Stream in_sel=0..7 on consecutive cycles with out_ready=1 -> out_data sequence 0x10..0x17 on 8 consecutive cycles, no gaps.
REQ-034 out_ready=0, push until in_ready=0 -> exactly 3 transfers accepted; then out_ready=1 -> all 3 emerge in order, then in_ready=1.
REQ-035 Pipe full, out_ready=1 and in_valid=1 in the same cycle -> one transfer out and one in, occupancy stays 3.
REQ-036 Pipe holding 2 items, rst_n=0 for one edge -> next cycle out_valid=0, out_data=0, in_ready=1, and no stale data emerges afterwards.
REQ-037 NUM_SEL=1, DATA_W=4, in_data={0xA,0x5}, in_sel=1 -> out_data=0xA after 1 cycle.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// -----------------------------------------------------------------------------
// pipe_mux_pkg
// Purpose : Shared constants and helpers for the pipelined mux tree.
//           Holds the default tree depth and channel width, plus a helper
//           that returns how many words a given tree level holds.
// Contents:
//   DEFAULT_NUM_SEL - default select width / tree depth
//   DEFAULT_DATA_W  - default width of one input channel
//   stageWords()    - word count held by level 'level' of a tree of depth
//                     'numSel' (level 0 is nearest the inputs)
// -----------------------------------------------------------------------------
package pipe_mux_pkg;

    localparam int DEFAULT_NUM_SEL = 4;
    localparam int DEFAULT_DATA_W  = 1;

    // Each level halves the word count, so level i keeps 2**(numSel-1-i) words
    // and the last level keeps exactly one.
    function automatic int stageWords(input int numSel, input int level);
        return 1 << (numSel - 1 - level);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// -----------------------------------------------------------------------------
// mux_tree_stage
// Purpose : One registered halving level of the mux tree. It selects between
//           adjacent pairs of upstream words using the lowest select bit it
//           receives, registers the result together with the remaining
//           (not yet used) select bits and a valid flag, and takes part in a
//           valid/ready handshake with its neighbours.
// Parameters:
//   NUM_WORDS - words held by this stage (upstream supplies twice as many)
//   DATA_W    - width of one word
//   SEL_W     - number of select bits carried to later stages (may be 0)
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   i_upData   - upstream words, word j at [j*DATA_W +: DATA_W]
//   i_upSel    - upstream select bits; bit 0 is consumed here
//   i_upValid  - upstream word/select are valid
//   o_upReady  - this stage can take the upstream word this cycle
//   o_dnData   - registered words for the next stage
//   o_dnSel    - registered carried select bits
//   o_dnValid  - registered valid flag
//   i_dnReady  - next stage can take this stage's contents
// -----------------------------------------------------------------------------
module mux_tree_stage
    import pipe_mux_pkg::*;
#(
    parameter  int NUM_WORDS = 1,
    parameter  int DATA_W    = 1,
    parameter  int SEL_W     = 0,
    localparam int CARRY_W   = (SEL_W > 0) ? SEL_W : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*NUM_WORDS*DATA_W-1:0] i_upData,
    input  logic [SEL_W:0]                i_upSel,
    input  logic                          i_upValid,
    output logic                          o_upReady,
    output logic [NUM_WORDS*DATA_W-1:0]   o_dnData,
    output logic [CARRY_W-1:0]            o_dnSel,
    output logic                          o_dnValid,
    input  logic                          i_dnReady
);

    logic [NUM_WORDS*DATA_W-1:0] r_data;
    logic [CARRY_W-1:0]          r_sel;
    logic                        r_valid;

    logic [NUM_WORDS*DATA_W-1:0] w_muxed;
    logic [CARRY_W-1:0]          w_carry;
    logic                        w_load;

    // An empty stage always has room, so bubbles collapse even when the
    // downstream side is stalled.
    assign o_upReady = !r_valid || i_dnReady;

    // Data and select only move on a real transfer so the stage keeps its
    // last word while it sits empty.
    assign w_load = o_upReady && i_upValid;

    always_comb begin
        w_muxed = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            w_muxed[j*DATA_W +: DATA_W] = i_upSel[0]
                ? i_upData[(2*j+1)*DATA_W +: DATA_W]
                : i_upData[(2*j)*DATA_W   +: DATA_W];
        end
    end

    // The last level has no select bits left to carry; it keeps a single
    // constant-zero bit so the port never collapses to zero width.
    if (SEL_W > 0) begin : g_carry
        assign w_carry = i_upSel[SEL_W:1];
    end else begin : g_noCarry
        assign w_carry = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else begin
            if (o_upReady) begin
                r_valid <= i_upValid;
            end
            if (w_load) begin
                r_data <= w_muxed;
                r_sel  <= w_carry;
            end
        end
    end

    assign o_dnData  = r_data;
    assign o_dnSel   = r_sel;
    assign o_dnValid = r_valid;

endmodule

// File: rtl/pipe_mux_tree.sv
// -----------------------------------------------------------------------------
// pipe_mux_tree
// Purpose : Pipelined 2**NUM_SEL : 1 multiplexer built as a tree of NUM_SEL
//           registered halving stages with a valid/ready handshake at both
//           ends. Latency is NUM_SEL cycles, throughput one word per cycle.
// Parameters:
//   NUM_SEL - select width and tree depth (1..8)
//   DATA_W  - width of one input channel (1..64)
//   NUM_IN  - derived channel count, 2**NUM_SEL
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   in_data   - channel k at [k*DATA_W +: DATA_W]
//   in_sel    - index of the channel to forward
//   in_valid  - in_data/in_sel valid this cycle
//   in_ready  - tree accepts a transfer this cycle
//   out_data  - selected channel value (registered)
//   out_valid - out_data valid this cycle
//   out_ready - consumer accepts out_data this cycle
// -----------------------------------------------------------------------------
module pipe_mux_tree
    import pipe_mux_pkg::*;
#(
    parameter  int NUM_SEL = DEFAULT_NUM_SEL,
    parameter  int DATA_W  = DEFAULT_DATA_W,
    localparam int NUM_IN  = 2**NUM_SEL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_SEL-1:0]       in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Index i is the valid/ready pair between stage i-1 and stage i; index 0
    // is the block input and index NUM_SEL is the block output.
    logic [NUM_SEL:0] w_valid;
    logic [NUM_SEL:0] w_ready;
    logic             w_unusedSel;

    assign w_valid[0]       = in_valid;
    assign w_ready[NUM_SEL] = out_ready;
    assign in_ready         = w_ready[0];
    assign out_valid        = w_valid[NUM_SEL];

    for (genvar i = 0; i < NUM_SEL; i++) begin : g_stage
        localparam int WORDS   = stageWords(NUM_SEL, i);
        localparam int SEL_W   = NUM_SEL - 1 - i;
        localparam int CARRY_W = (SEL_W > 0) ? SEL_W : 1;

        logic [2*WORDS*DATA_W-1:0] w_dataIn;
        logic [SEL_W:0]            w_selIn;
        logic [WORDS*DATA_W-1:0]   w_dataOut;
        logic [CARRY_W-1:0]        w_selOut;

        // The first stage sees the raw channels and full select; later stages
        // see the previous stage's words and its carried select bits, which
        // are already shifted so the bit they need sits at position 0.
        if (i == 0) begin : g_first
            assign w_dataIn = in_data;
            assign w_selIn  = in_sel;
        end else begin : g_inner
            assign w_dataIn = g_stage[i-1].w_dataOut;
            assign w_selIn  = g_stage[i-1].w_selOut;
        end

        mux_tree_stage #(
            .NUM_WORDS (WORDS),
            .DATA_W    (DATA_W),
            .SEL_W     (SEL_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_upData  (w_dataIn),
            .i_upSel   (w_selIn),
            .i_upValid (w_valid[i]),
            .o_upReady (w_ready[i]),
            .o_dnData  (w_dataOut),
            .o_dnSel   (w_selOut),
            .o_dnValid (w_valid[i+1]),
            .i_dnReady (w_ready[i+1])
        );
    end

    assign out_data = g_stage[NUM_SEL-1].w_dataOut;

    // The last stage carries no select bits, only a single constant-zero bit.
    assign w_unusedSel = g_stage[NUM_SEL-1].w_selOut;

endmodule

// File: tb/tb_pipe_mux_tree.sv
// -----------------------------------------------------------------------------
// tb_pipe_mux_tree
// Purpose : Directed self-checking bench for pipe_mux_tree. One instance uses
//           an 8-channel byte-wide tree (three levels), a second uses the
//           single-level 2:1 configuration with 4-bit channels.
// -----------------------------------------------------------------------------
module tb_pipe_mux_tree;

    logic clk = 1'b0;
    logic rst_n;

    logic [63:0] aInData;
    logic [2:0]  aInSel;
    logic        aInValid;
    logic        aInReady;
    logic [7:0]  aOutData;
    logic        aOutValid;
    logic        aOutReady;

    logic [7:0]  bInData;
    logic        bInSel;
    logic        bInValid;
    logic        bInReady;
    logic [3:0]  bOutData;
    logic        bOutValid;
    logic        bOutReady;

    int passCount  = 0;
    int checkCount = 0;
    int accepted;

    always #5 clk = ~clk;

    pipe_mux_tree #(.NUM_SEL(3), .DATA_W(8)) u_dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (aInData),
        .in_sel    (aInSel),
        .in_valid  (aInValid),
        .in_ready  (aInReady),
        .out_data  (aOutData),
        .out_valid (aOutValid),
        .out_ready (aOutReady)
    );

    pipe_mux_tree #(.NUM_SEL(1), .DATA_W(4)) u_dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (bInData),
        .in_sel    (bInSel),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .out_data  (bOutData),
        .out_valid (bOutValid),
        .out_ready (bOutReady)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the handshake inputs of the three-level instance.
    task automatic applyStimulus(input logic valid, input logic [2:0] sel,
                                 input logic outReady);
        aInValid  = valid;
        aInSel    = sel;
        aOutReady = outReady;
    endtask

    // Advance one clock and move just past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            aInData[k*8 +: 8] = 8'(8'h10 + k);
        end
        bInData   = 8'hA5;
        bInSel    = 1'b0;
        bInValid  = 1'b0;
        bOutReady = 1'b1;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rst_a_valid", aOutValid, 0);
        checkOutput("rst_a_data",  aOutData,  0);
        checkOutput("rst_a_ready", aInReady,  1);
        checkOutput("rst_b_valid", bOutValid, 0);
        checkOutput("rst_b_data",  bOutData,  0);
        checkOutput("rst_b_ready", bInReady,  1);

        // Single transfer, channel 5, latency of three cycles
        applyStimulus(1'b1, 3'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b1);
        checkOutput("lat_c1_valid", aOutValid, 0);
        tick();
        checkOutput("lat_c2_valid", aOutValid, 0);
        tick();
        checkOutput("lat_c3_valid", aOutValid, 1);
        checkOutput("lat_c3_data",  aOutData,  8'h15);
        tick();
        checkOutput("lat_drained", aOutValid, 0);

        // Back-to-back stream of every channel
        for (int t = 0; t < 11; t++) begin
            if (t < 8) applyStimulus(1'b1, 3'(t), 1'b1);
            else       applyStimulus(1'b0, 3'd0, 1'b1);
            tick();
            checkOutput($sformatf("stream_valid_%0d", t), aOutValid,
                        (t >= 2 && t <= 9) ? 64'd1 : 64'd0);
            if (t >= 2 && t <= 9) begin
                checkOutput($sformatf("stream_data_%0d", t), aOutData, 64'(8'h10 + t - 2));
            end
        end

        // Fill under backpressure until the tree refuses input
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 3'(1 + accepted), 1'b0);
            #1;
            if (!aInReady) break;
            tick();
            accepted++;
        end
        checkOutput("fill_count", accepted,  3);
        checkOutput("fill_ready", aInReady,  0);
        checkOutput("fill_valid", aOutValid, 1);
        checkOutput("fill_data",  aOutData,  8'h11);

        // Stalled tree holds its contents and keeps refusing input
        applyStimulus(1'b1, 3'd7, 1'b0);
        tick();
        checkOutput("hold_valid", aOutValid, 1);
        checkOutput("hold_data",  aOutData,  8'h11);
        checkOutput("hold_ready", aInReady,  0);

        // Simultaneous accept at both ends while full
        applyStimulus(1'b1, 3'd4, 1'b1);
        tick();
        checkOutput("swap_valid", aOutValid, 1);
        checkOutput("swap_data",  aOutData,  8'h12);
        applyStimulus(1'b0, 3'd0, 1'b0);
        #1;
        checkOutput("swap_still_full", aInReady, 0);

        // Drain the remaining items in order
        applyStimulus(1'b0, 3'd0, 1'b1);
        tick();
        checkOutput("drain_data_1", aOutData, 8'h13);
        tick();
        checkOutput("drain_valid_2", aOutValid, 1);
        checkOutput("drain_data_2",  aOutData,  8'h14);
        tick();
        checkOutput("drain_empty", aOutValid, 0);
        checkOutput("drain_ready", aInReady,  1);

        // Reset with two items in flight discards them
        applyStimulus(1'b1, 3'd6, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd7, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("pre_rst_valid", aOutValid, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mid_rst_valid", aOutValid, 0);
        checkOutput("mid_rst_data",  aOutData,  0);
        checkOutput("mid_rst_ready", aInReady,  1);
        applyStimulus(1'b0, 3'd0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput($sformatf("no_stale_%0d", t), aOutValid, 0);
        end

        // Single-level 2:1 tree: channel 1 = 0xA, channel 0 = 0x5
        bInData   = {4'hA, 4'h5};
        bInSel    = 1'b1;
        bInValid  = 1'b1;
        bOutReady = 1'b1;
        tick();
        checkOutput("b_lat1_valid", bOutValid, 1);
        checkOutput("b_lat1_data",  bOutData,  4'hA);
        bInSel = 1'b0;
        tick();
        checkOutput("b_sel0_valid", bOutValid, 1);
        checkOutput("b_sel0_data",  bOutData,  4'h5);
        bInValid = 1'b0;
        tick();
        checkOutput("b_empty", bOutValid, 0);

        // Single-level tree under backpressure
        bOutReady = 1'b0;
        bInValid  = 1'b1;
        bInSel    = 1'b1;
        tick();
        checkOutput("b_stall_data",  bOutData, 4'hA);
        checkOutput("b_stall_ready", bInReady, 0);
        bInSel = 1'b0;
        tick();
        checkOutput("b_stall_hold", bOutData, 4'hA);
        bOutReady = 1'b1;
        tick();
        checkOutput("b_swap_valid", bOutValid, 1);
        checkOutput("b_swap_data",  bOutData,  4'h5);
        bInValid = 1'b0;
        tick();
        checkOutput("b_final_empty", bOutValid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
